// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nco_pkg
//  Purpose  : Shared definitions for the NCO dither generator and checker.
//             Holds the LFSR seed, the feedback tap mask, the feedback
//             function and the checker state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package nco_pkg;

    // Generator reset value.
    localparam logic [7:0] DITHER_SEED = 8'hAA;

    // x^8+x^6+x^5+x^4+1 expressed on history bits (hist[0] newest):
    // s(k+1) = s(k-3)^s(k-4)^s(k-5)^s(k-7)
    localparam logic [7:0] DITHER_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        FILL   = 2'b00,
        CHECK  = 2'b01,
        LOCKED = 2'b10
    } dither_state_t;

    function automatic logic dither_fb(input logic [7:0] hist);
        return ^(hist & DITHER_TAPS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dither_checker.sv
`default_nettype none
// ============================================================================
//  Module   : dither_checker
//  Purpose  : Receive-side checker for the NCO dither nibble stream.
//             Fills an 8-bit history from the incoming nibbles, checks the
//             prediction until LOCK_CNT consecutive matches, then flywheels
//             on its own prediction and counts mismatches.
//  Ports    : iclk      clock
//             iresetn   asynchronous active-low reset
//             inCS      active-low sample enable (idata valid when low)
//             idata     received nibble, [3] oldest bit
//             iclr_err  synchronous clear of oerr_cnt
//             olock     1 = locked
//             oerr      one-cycle pulse on a mismatch while locked
//             oerr_cnt  saturating mismatch count
//             ostate    FSM state (00 FILL, 01 CHECK, 10 LOCKED)
//  Revision : 1.0  initial release
// ============================================================================
module dither_checker
    import nco_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             iclk,
    input  logic             iresetn,
    input  logic             inCS,
    input  logic [3:0]       idata,
    input  logic             iclr_err,
    output logic             olock,
    output logic             oerr,
    output logic [ERR_W-1:0] oerr_cnt,
    output logic [1:0]       ostate
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    dither_state_t      state, state_nx;
    logic [7:0]         hist, hist_nx;
    logic [2:0]         fill_cnt, fill_nx;
    logic [MATCH_W-1:0] match_cnt, match_nx;
    logic [MISS_W-1:0]  miss_cnt, miss_nx;
    logic               lock_nx, err_nx;
    logic [ERR_W-1:0]   cnt_nx;

    logic               fb;
    logic [3:0]         expected;
    logic               err_hit;

    assign fb       = dither_fb(hist);
    assign expected = {hist[2:0], fb};
    assign ostate   = state;

    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            state     <= FILL;
            hist      <= 8'h00;
            fill_cnt  <= 3'd0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            olock     <= 1'b0;
            oerr      <= 1'b0;
            oerr_cnt  <= '0;
        end else begin
            state     <= state_nx;
            hist      <= hist_nx;
            fill_cnt  <= fill_nx;
            match_cnt <= match_nx;
            miss_cnt  <= miss_nx;
            olock     <= lock_nx;
            oerr      <= err_nx;
            oerr_cnt  <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hist_nx  = hist;
        fill_nx  = fill_cnt;
        match_nx = match_cnt;
        miss_nx  = miss_cnt;
        lock_nx  = olock;
        err_nx   = 1'b0;
        err_hit  = 1'b0;
        cnt_nx   = oerr_cnt;

        if (!inCS) begin
            case (state)
                FILL: begin
                    hist_nx = {hist[6:0], idata[0]};
                    if (fill_cnt == 3'd7) begin
                        fill_nx  = 3'd0;
                        state_nx = CHECK;
                    end else begin
                        fill_nx = fill_cnt + 3'd1;
                    end
                end
                CHECK: begin
                    hist_nx = {hist[6:0], idata[0]};
                    // An all-zero history is the LFSR lock-up state; a stuck
                    // zero stream would otherwise "match" forever.
                    if ((idata == expected) && (hist != 8'h00)) begin
                        if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            match_nx = '0;
                            state_nx = LOCKED;
                            lock_nx  = 1'b1;
                        end else begin
                            match_nx = match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        match_nx = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: received errors never enter the history.
                    hist_nx = {hist[6:0], fb};
                    if (idata != expected) begin
                        err_nx  = 1'b1;
                        err_hit = 1'b1;
                        if (miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
                            miss_nx  = '0;
                            match_nx = '0;
                            fill_nx  = 3'd0;
                            state_nx = FILL;
                            lock_nx  = 1'b0;
                        end else begin
                            miss_nx = miss_cnt + MISS_W'(1);
                        end
                    end else begin
                        miss_nx = '0;
                    end
                end
                default: begin
                    state_nx = FILL;
                    lock_nx  = 1'b0;
                end
            endcase
        end

        // A clear coinciding with an error leaves that error counted.
        if (iclr_err) begin
            cnt_nx = err_hit ? ERR_W'(1) : '0;
        end else if (err_hit && (oerr_cnt != '1)) begin
            cnt_nx = oerr_cnt + ERR_W'(1);
        end
    end

endmodule
`default_nettype wire
